// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants and FSM state encoding for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // 4-bit operation select encodings
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_SLT  = 4'b0100;
    localparam logic [3:0] c_OP_PASS = 4'b0101;
    localparam logic [3:0] c_OP_XOR  = 4'b0110;
    localparam logic [3:0] c_OP_NOR  = 4'b0111;
    localparam logic [3:0] c_OP_SLL  = 4'b1000;
    localparam logic [3:0] c_OP_SRL  = 4'b1001;
    localparam logic [3:0] c_OP_SRA  = 4'b1010;
    localparam logic [3:0] c_OP_SLTU = 4'b1011;
    localparam logic [3:0] c_OP_MUL  = 4'b1100;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Single-cycle combinational ALU datapath with Z/N/C/V/err
//               flags. MUL is accepted as legal here but its result comes from
//               the iterative multiplier in the parent block.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [3:0]       alu_sel_i,
    output logic [WIDTH-1:0] res_o,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o,
    output logic             v_o,
    output logic             err_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;

    // Extra top bit of the unsigned add/subtract gives carry-out / borrow.
    assign w_sum   = {1'b0, op1_i} + {1'b0, op2_i};
    assign w_diff  = {1'b0, op1_i} - {1'b0, op2_i};
    assign w_shamt = op2_i[SHW-1:0];

    // Operation decode: result, carry, overflow and illegal-opcode detection
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (alu_sel_i)
            c_OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (op1_i[WIDTH-1] == op2_i[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != op1_i[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (op1_i[WIDTH-1] != op2_i[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != op1_i[WIDTH-1]);
            end
            c_OP_AND:  w_res = op1_i & op2_i;
            c_OP_OR:   w_res = op1_i | op2_i;
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
            c_OP_PASS: w_res = op1_i;
            c_OP_XOR:  w_res = op1_i ^ op2_i;
            c_OP_NOR:  w_res = ~(op1_i | op2_i);
            c_OP_SLL:  w_res = op1_i << w_shamt;
            c_OP_SRL:  w_res = op1_i >> w_shamt;
            c_OP_SRA:  w_res = $unsigned($signed(op1_i) >>> w_shamt);
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (op1_i < op2_i)};
            c_OP_MUL:  w_res = '0;
            default:   w_err = 1'b1;
        endcase
    end

    assign res_o = w_res;
    assign z_o   = !w_err && (w_res == '0);
    assign n_o   = w_res[WIDTH-1];
    assign c_o   = w_c;
    assign v_o   = w_v;
    assign err_o = w_err;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_fase_2.sv
`default_nettype none
// ============================================================================
// Module      : alu_fase_2
// Description : Handshaked ALU. Single-cycle ops complete one cycle after
//               accept; MUL runs a WIDTH-cycle shift-add multiplier. Result
//               and flags are held until the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_fase_2
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [3:0]       ALUSel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Res,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             err
);

    localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             z_q;
    logic             n_q;
    logic             c_q;
    logic             v_q;
    logic             err_q;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_core_res;
    logic             w_core_z;
    logic             w_core_n;
    logic             w_core_c;
    logic             w_core_v;
    logic             w_core_err;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op1_i     (OP1),
        .op2_i     (OP2),
        .alu_sel_i (ALUSel),
        .res_o     (w_core_res),
        .z_o       (w_core_z),
        .n_o       (w_core_n),
        .c_o       (w_core_c),
        .v_o       (w_core_v),
        .err_o     (w_core_err)
    );

    assign w_accept   = in_valid && (state_q == ST_IDLE);
    assign w_is_mul   = (ALUSel == c_OP_MUL);
    assign w_mul_last = (state_q == ST_MUL) && (cnt_q == c_CNT_LAST);
    // One multiplier bit per cycle, LSB first, against a left-shifting multiplicand.
    assign w_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: accept only in IDLE, release DONE on out_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = w_is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_mul_last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Iterative shift-add multiplier; always runs the full WIDTH iterations
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (w_accept && w_is_mul) begin
            mcand_q  <= OP1;
            mplier_q <= OP2;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == ST_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= w_acc_next;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // Result/flag registers: loaded at single-cycle accept or final MUL step, else held
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            err_q <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            res_q <= w_core_res;
            z_q   <= w_core_z;
            n_q   <= w_core_n;
            c_q   <= w_core_c;
            v_q   <= w_core_v;
            err_q <= w_core_err;
        end else if (w_mul_last) begin
            res_q <= w_acc_next;
            z_q   <= (w_acc_next == '0);
            n_q   <= w_acc_next[WIDTH-1];
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            err_q <= 1'b0;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Res       = res_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;
    assign err       = err_q;

endmodule : alu_fase_2
`default_nettype wire

// File: tb/tb_alu_fase_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_fase_2
// Description : Self-checking bench for alu_fase_2 (WIDTH=32): directed corner
//               cases followed by randomized operations against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_fase_2;

    localparam int W = 32;
    localparam longint c_SMAX = 64'sd2147483647;
    localparam longint c_SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] OP1 = '0;
    logic [W-1:0] OP2 = '0;
    logic [3:0]   ALUSel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Res;
    logic         Z, N, C, V, err;

    int checks = 0;
    int errors = 0;

    alu_fase_2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OP1       (OP1),
        .OP2       (OP2),
        .ALUSel    (ALUSel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Res       (Res),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: result and flags from plain integer arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                                  output logic [31:0] r, output logic z, output logic n,
                                  output logic c, output logic v, output logic e);
        longint sa, sb, st;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (s)
            4'd0: begin
                wide = {32'd0, a} + {32'd0, b};
                r = wide[31:0]; c = wide[32];
                st = sa + sb; v = (st > c_SMAX) || (st < c_SMIN);
            end
            4'd1: begin
                r = a - b; c = (a < b);
                st = sa - sb; v = (st > c_SMAX) || (st < c_SMIN);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  r = a;
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a | b);
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: begin st = sa / (64'sd1 << b[4:0]); if (sa < 0 && (sa % (64'sd1 << b[4:0])) != 0) st = st - 1; r = st[31:0]; end
            4'd11: r = (a < b) ? 32'd1 : 32'd0;
            4'd12: begin wide = {32'd0, a} * {32'd0, b}; r = wide[31:0]; end
            default: e = 1'b1;
        endcase
        z = !e && (r == 32'd0);
        n = r[31];
    endfunction

    // Issue one request, check latency and outputs, hold DONE for 'hold' cycles, then release
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s, input int hold, input bit pulse);
        logic [31:0] er;
        logic ez, en, ec, ev, ee;
        int lat;
        int exp_lat;
        model(a, b, s, er, ez, en, ec, ev, ee);
        exp_lat = (s == 4'd12) ? W + 1 : 1;
        @(negedge clk);
        chk({tag, "_ready_pre"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; OP1 = a; OP2 = b; ALUSel = s; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (pulse) begin
                chk({tag, "_ready_busy"}, 64'(in_ready), 64'd0);
                in_valid = 1'($urandom_range(0, 1));
                OP1 = $urandom; OP2 = $urandom; ALUSel = 4'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(Res), 64'(er));
        chk({tag, "_flags"}, 64'({Z, N, C, V, err}), 64'({ez, en, ec, ev, ee}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_res"}, 64'(Res), 64'(er));
            chk({tag, "_hold_hs"}, 64'({out_valid, in_ready}), 64'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_res", 64'(Res), 64'd0);
        chk("reset_flags", 64'({Z, N, C, V, err}), 64'd0);
        chk("reset_hs", 64'({out_valid, in_ready}), 64'b01);

        run_op("add_wrap",  32'hFFFFFFFF, 32'h1, 4'd0, 0, 1'b0);
        run_op("sub_ovf",   32'h80000000, 32'h1, 4'd1, 0, 1'b0);
        run_op("slt",       32'hFFFFFFFF, 32'h1, 4'd4, 0, 1'b0);
        run_op("sltu",      32'hFFFFFFFF, 32'h1, 4'd11, 0, 1'b0);
        run_op("mul_dir",   32'h0000FFFF, 32'h00010001, 4'd12, 0, 1'b1);
        run_op("mul_zero",  32'h0, 32'h12345678, 4'd12, 0, 1'b0);
        run_op("sra",       32'h80000000, 32'h24, 4'd10, 0, 1'b0);
        run_op("srl",       32'h80000000, 32'h24, 4'd9, 0, 1'b0);
        run_op("backpress", 32'hF0F0F0F0, 32'h0FF00FF0, 4'd2, 5, 1'b0);
        run_op("illegal",   32'h12345678, 32'h9ABCDEF0, 4'd15, 0, 1'b0);

        // Reset in the middle of a multiply aborts it
        @(negedge clk);
        in_valid = 1'b1; OP1 = 32'h1234; OP2 = 32'h5678; ALUSel = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmul_res", 64'(Res), 64'd0);
        chk("rstmul_flags", 64'({Z, N, C, V, err}), 64'd0);
        chk("rstmul_hs", 64'({out_valid, in_ready}), 64'b01);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rstmul_no_valid", 64'(seen), 64'd0);
        run_op("add_after_rst", 32'd2, 32'd3, 4'd0, 0, 1'b0);

        // Randomized operations with random backpressure
        for (int k = 0; k < 40; k++) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 15));
            run_op("rand", $urandom, $urandom, s, int'($urandom_range(0, 3)), s == 4'd12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_fase_2
`default_nettype wire
